// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS execute stage: ALU opcodes, funct codes,
// control-bus bit positions and the multiplier FSM state type.
package mips_pkg;

  localparam logic [1:0] AluOpAdd   = 2'b00;
  localparam logic [1:0] AluOpSub   = 2'b01;
  localparam logic [1:0] AluOpRtype = 2'b10;
  localparam logic [1:0] AluOpOr    = 2'b11;

  localparam logic [5:0] FunctAdd  = 6'h20;
  localparam logic [5:0] FunctSub  = 6'h22;
  localparam logic [5:0] FunctAnd  = 6'h24;
  localparam logic [5:0] FunctOr   = 6'h25;
  localparam logic [5:0] FunctSlt  = 6'h2A;
  localparam logic [5:0] FunctMult = 6'h18;

  localparam int unsigned WbRegWrite = 1;
  localparam int unsigned WbMemToReg = 0;
  localparam int unsigned MemBranch  = 2;
  localparam int unsigned MemRead    = 1;
  localparam int unsigned MemWrite   = 0;
  localparam int unsigned ExeRegDst  = 2;

  typedef enum logic {StIdle, StMul} mul_state_e;

  function automatic logic is_mult(input logic [1:0] alu_op, input logic [5:0] funct);
    return (alu_op == AluOpRtype) && (funct == FunctMult);
  endfunction

endpackage

// File: rtl/alu32.sv
// Combinational ALU for the execute stage. MULT is not handled here; the
// iterative multiplier in exe_stage supplies that result.
module alu32
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [1:0]        alu_op,
  input  logic [5:0]        funct,
  output logic [DATA_W-1:0] result,
  output logic              zero
);

  always_comb begin
    result = '0;
    unique case (alu_op)
      AluOpAdd: result = a + b;
      AluOpSub: result = a - b;
      AluOpOr:  result = a | b;
      AluOpRtype: begin
        case (funct)
          FunctAdd: result = a + b;
          FunctSub: result = a - b;
          FunctAnd: result = a & b;
          FunctOr:  result = a | b;
          FunctSlt: result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
          default:  result = '0;
        endcase
      end
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/exe_stage.sv
// MIPS execute stage: operand forwarding, ALU, branch target, iterative
// shift-add multiplier and the EX/MEM pipeline register.
module exe_stage
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned PC_W   = 7
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [PC_W-1:0]   pc,
  input  logic [DATA_W-1:0] readData1,
  input  logic [DATA_W-1:0] readData2,
  input  logic [DATA_W-1:0] sign_extended,
  input  logic [4:0]        instruction1,
  input  logic [4:0]        instruction2,
  input  logic [4:0]        rs,
  input  logic [1:0]        WB,
  input  logic [2:0]        MEM,
  input  logic [2:0]        EXE,
  input  logic              flush,
  input  logic              memWbRegWrite,
  input  logic [4:0]        memWbRd,
  input  logic [DATA_W-1:0] memWbData,
  output logic              stall,
  output logic [DATA_W-1:0] aluResultOut,
  output logic [DATA_W-1:0] writeDataOut,
  output logic [4:0]        destRegOut,
  output logic              zeroOut,
  output logic [PC_W-1:0]   branchTargetOut,
  output logic [1:0]        WBOut,
  output logic [2:0]        MEMOut
);

  localparam int unsigned CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DATA_W - 1);

  logic [1:0]        alu_op;
  logic [5:0]        funct;
  logic              start_mult;
  logic [4:0]        dest;
  logic [DATA_W-1:0] fwd_a, fwd_b, alu_b, alu_result;
  logic              alu_zero;
  logic              exmem_fwd_ok, memwb_fwd_ok;

  mul_state_e        state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
  logic [DATA_W-1:0] partial, acc_sum;
  logic [4:0]        mul_dest_q, mul_dest_d;
  logic [1:0]        mul_wb_q, mul_wb_d;
  logic [2:0]        mul_mem_q, mul_mem_d;

  logic [DATA_W-1:0] alu_d, wdata_d;
  logic [4:0]        dest_d;
  logic              zero_d;
  logic [PC_W-1:0]   bt_d;
  logic [1:0]        wb_d;
  logic [2:0]        mem_d;

  assign alu_op     = EXE[1:0];
  assign funct      = sign_extended[5:0];
  assign start_mult = is_mult(alu_op, funct);
  assign dest       = EXE[ExeRegDst] ? instruction2 : instruction1;

  // Loads (MemToReg=1) in EX/MEM have no data yet; the hazard unit covers them.
  assign exmem_fwd_ok = WBOut[WbRegWrite] && !WBOut[WbMemToReg] && (destRegOut != 5'd0);
  assign memwb_fwd_ok = memWbRegWrite && (memWbRd != 5'd0);

  always_comb begin
    fwd_a = readData1;
    if (exmem_fwd_ok && (destRegOut == rs)) begin
      fwd_a = aluResultOut;
    end else if (memwb_fwd_ok && (memWbRd == rs)) begin
      fwd_a = memWbData;
    end
  end

  always_comb begin
    fwd_b = readData2;
    if (exmem_fwd_ok && (destRegOut == instruction1)) begin
      fwd_b = aluResultOut;
    end else if (memwb_fwd_ok && (memWbRd == instruction1)) begin
      fwd_b = memWbData;
    end
  end

  assign alu_b = ((alu_op == AluOpAdd) || (alu_op == AluOpOr)) ? sign_extended : fwd_b;

  alu32 #(
    .DATA_W(DATA_W)
  ) u_alu (
    .a      (fwd_a),
    .b      (alu_b),
    .alu_op (alu_op),
    .funct  (funct),
    .result (alu_result),
    .zero   (alu_zero)
  );

  assign partial = mplier_q[count_q] ? (mcand_q << count_q) : '0;
  assign acc_sum = acc_q + partial;

  // Default EX/MEM capture is a bubble; only a live instruction or a finished
  // multiply overrides it.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    acc_d      = acc_q;
    mul_dest_d = mul_dest_q;
    mul_wb_d   = mul_wb_q;
    mul_mem_d  = mul_mem_q;
    stall      = 1'b0;
    alu_d      = '0;
    wdata_d    = '0;
    dest_d     = '0;
    zero_d     = 1'b0;
    bt_d       = '0;
    wb_d       = '0;
    mem_d      = '0;
    unique case (state_q)
      StIdle: begin
        if (!flush) begin
          if (start_mult) begin
            stall      = 1'b1;
            mcand_d    = fwd_a;
            mplier_d   = fwd_b;
            acc_d      = '0;
            count_d    = '0;
            mul_dest_d = dest;
            mul_wb_d   = WB;
            mul_mem_d  = MEM;
            state_d    = StMul;
          end else begin
            alu_d   = alu_result;
            wdata_d = fwd_b;
            dest_d  = dest;
            zero_d  = alu_zero;
            bt_d    = pc + sign_extended[PC_W-1:0];
            wb_d    = WB;
            mem_d   = MEM;
          end
        end
      end
      StMul: begin
        if (flush) begin
          state_d = StIdle;
          count_d = '0;
        end else begin
          acc_d   = acc_sum;
          count_d = count_q + CNT_W'(1);
          if (count_q == CntLast) begin
            state_d = StIdle;
            count_d = '0;
            alu_d   = acc_sum;
            zero_d  = (acc_sum == '0);
            dest_d  = mul_dest_q;
            wb_d    = mul_wb_q;
            mem_d   = mul_mem_q;
          end else begin
            stall = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= StIdle;
      count_q         <= '0;
      mcand_q         <= '0;
      mplier_q        <= '0;
      acc_q           <= '0;
      mul_dest_q      <= '0;
      mul_wb_q        <= '0;
      mul_mem_q       <= '0;
      aluResultOut    <= '0;
      writeDataOut    <= '0;
      destRegOut      <= '0;
      zeroOut         <= 1'b0;
      branchTargetOut <= '0;
      WBOut           <= '0;
      MEMOut          <= '0;
    end else begin
      state_q         <= state_d;
      count_q         <= count_d;
      mcand_q         <= mcand_d;
      mplier_q        <= mplier_d;
      acc_q           <= acc_d;
      mul_dest_q      <= mul_dest_d;
      mul_wb_q        <= mul_wb_d;
      mul_mem_q       <= mul_mem_d;
      aluResultOut    <= alu_d;
      writeDataOut    <= wdata_d;
      destRegOut      <= dest_d;
      zeroOut         <= zero_d;
      branchTargetOut <= bt_d;
      WBOut           <= wb_d;
      MEMOut          <= mem_d;
    end
  end

endmodule
